my_step_ramp_gen_v1: RTL and testbench

// Closed-loop feedback stage downstream of the error-signal generator. Each error strobe is

---
 rtl/my_loop_pkg.sv | 36 +++
 rtl/my_sat_integrator.sv | 47 ++++
 rtl/my_step_ramp_gen_v1.sv | 121 ++++++++++++
 tb/tb_my_step_ramp_gen_v1.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_loop_pkg.sv
// Shared definitions for the phase-loop feedback path: state encoding, default widths
// and the symmetric saturating adder used by the step integrator.
package my_loop_pkg;

  localparam int DEF_ERR_W   = 32;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_DAC_BIT = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_ERR = 3'd1,
    S_SCALE    = 3'd2,
    S_INTEG    = 3'd3,
    S_RAMP     = 3'd4,
    S_OUT      = 3'd5
  } state_t;

  // One extra bit of headroom so the sum cannot overflow before it is clamped;
  // lim has a zero MSB, so -lim always fits back into DEF_ACC_W bits.
  function automatic logic signed [DEF_ACC_W-1:0] sat_add(
    input logic signed [DEF_ACC_W-1:0] a,
    input logic signed [DEF_ACC_W-1:0] b,
    input logic        [DEF_ACC_W-1:0] lim
  );
    logic signed [DEF_ACC_W:0] sum;
    logic signed [DEF_ACC_W:0] hi;
    logic signed [DEF_ACC_W:0] lo;
    sum = {a[DEF_ACC_W-1], a} + {b[DEF_ACC_W-1], b};
    hi  = {1'b0, lim};
    lo  = -hi;
    if (sum > hi)      return hi[DEF_ACC_W-1:0];
    else if (sum < lo) return lo[DEF_ACC_W-1:0];
    else               return sum[DEF_ACC_W-1:0];
  endfunction

endpackage

// File: rtl/my_sat_integrator.sv
// Error latch, gain scaling and saturated step integration. The FSM in the top decides
// when each stage fires; this block only holds the arithmetic and its registers.
module my_sat_integrator
  import my_loop_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_latch,
  input  logic                    i_scale,
  input  logic                    i_integ,
  input  logic                    i_loop_mode,
  input  logic signed [ERR_W-1:0] i_err,
  input  logic        [4:0]       i_gain_sel,
  input  logic        [ACC_W-1:0] i_step_lim,
  input  logic signed [ACC_W-1:0] i_const_step,
  output logic signed [ACC_W-1:0] o_step
);

  logic signed [ERR_W-1:0] r_err;
  logic signed [ACC_W-1:0] r_err_s;
  logic signed [ACC_W-1:0] r_step;
  logic signed [ERR_W-1:0] w_shift;
  logic signed [ACC_W-1:0] w_err_s;

  assign w_shift = r_err >>> i_gain_sel;
  assign w_err_s = ACC_W'(w_shift);

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous and clears every register, including r_err.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err   <= '0;
      r_err_s <= '0;
      r_step  <= '0;
    end else begin
      if (i_latch) r_err   <= i_err;
      if (i_scale) r_err_s <= w_err_s;
      if (i_integ) r_step  <= i_loop_mode ? sat_add(r_step, r_err_s, i_step_lim) : i_const_step;
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/my_step_ramp_gen_v1.sv
// Loop sequencer: accepts error strobes, walks SCALE/INTEG/RAMP/OUT, accumulates the
// wrapping phase ramp and counts strobes that arrive while a previous one is in flight.
module my_step_ramp_gen_v1
  import my_loop_pkg::*;
#(
  parameter int ERR_W   = DEF_ERR_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int DAC_BIT = DEF_DAC_BIT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_loop_mode,
  input  logic                    i_err_valid,
  input  logic signed [ERR_W-1:0] i_err,
  input  logic        [4:0]       i_gain_sel,
  input  logic        [ACC_W-1:0] i_step_lim,
  input  logic signed [ACC_W-1:0] i_const_step,
  output logic signed [ACC_W-1:0] o_step,
  output logic        [ACC_W-1:0] o_ramp,
  output logic      [DAC_BIT-1:0] o_dac,
  output logic                    o_ramp_valid,
  output logic                    o_ramp_wrap,
  output logic        [15:0]      o_drop_cnt,
  output logic                    o_busy,
  output logic        [2:0]       o_cstate
);

  state_t            r_state;
  state_t            w_next;
  logic [ACC_W-1:0]  r_ramp;
  logic              r_ramp_valid;
  logic              r_ramp_wrap;
  logic [15:0]       r_drop_cnt;
  logic signed [ACC_W-1:0] w_step;
  logic [ACC_W-1:0]  w_ramp_sum;
  logic              w_wrap;
  logic              w_busy;
  logic              w_latch;
  logic              w_scale;
  logic              w_integ;
  logic              w_ramp_en;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (!i_enable) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:     w_next = S_WAIT_ERR;
        S_WAIT_ERR: if (i_err_valid) w_next = S_SCALE;
        S_SCALE:    w_next = S_INTEG;
        S_INTEG:    w_next = S_RAMP;
        S_RAMP:     w_next = S_OUT;
        S_OUT:      w_next = S_WAIT_ERR;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  // Stage strobes are gated by i_enable so a disabled loop leaves o_step/o_ramp untouched.
  assign w_busy    = r_state inside {S_SCALE, S_INTEG, S_RAMP, S_OUT};
  assign w_latch   = i_enable && (r_state == S_WAIT_ERR) && i_err_valid;
  assign w_scale   = i_enable && (r_state == S_SCALE);
  assign w_integ   = i_enable && (r_state == S_INTEG);
  assign w_ramp_en = i_enable && (r_state == S_RAMP);

  my_sat_integrator #(
    .ERR_W (ERR_W),
    .ACC_W (ACC_W)
  ) u_integ (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_latch      (w_latch),
    .i_scale      (w_scale),
    .i_integ      (w_integ),
    .i_loop_mode  (i_loop_mode),
    .i_err        (i_err),
    .i_gain_sel   (i_gain_sel),
    .i_step_lim   (i_step_lim),
    .i_const_step (i_const_step),
    .o_step       (w_step)
  );

  // Modulo-2^ACC_W add; the wrap flag is signed overflow, i.e. the 2-pi phase reset.
  assign w_ramp_sum = r_ramp + w_step;
  assign w_wrap     = (r_ramp[ACC_W-1] == w_step[ACC_W-1]) &&
                      (w_ramp_sum[ACC_W-1] != r_ramp[ACC_W-1]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ramp       <= '0;
      r_ramp_valid <= 1'b0;
      r_ramp_wrap  <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      r_ramp_valid <= 1'b0;
      r_ramp_wrap  <= 1'b0;
      if (w_ramp_en) begin
        r_ramp       <= w_ramp_sum;
        r_ramp_valid <= 1'b1;
        r_ramp_wrap  <= w_wrap;
      end
      if (i_err_valid && w_busy && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_step       = w_step;
  assign o_ramp       = r_ramp;
  assign o_dac        = r_ramp[ACC_W-1 -: DAC_BIT];
  assign o_ramp_valid = r_ramp_valid;
  assign o_ramp_wrap  = r_ramp_wrap;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_busy       = w_busy;
  assign o_cstate     = r_state;

endmodule

// File: tb/tb_my_step_ramp_gen_v1.sv
// Self-checking bench for my_step_ramp_gen_v1: directed scenarios plus randomized strobes
// compared against an arithmetic model of the loop (scale, clamp, modulo ramp).
module tb_my_step_ramp_gen_v1;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_loop_mode = 1'b1;
  logic        i_err_valid = 1'b0;
  logic [31:0] i_err = '0;
  logic [4:0]  i_gain_sel = '0;
  logic [31:0] i_step_lim = '0;
  logic [31:0] i_const_step = '0;
  logic [31:0] o_step;
  logic [31:0] o_ramp;
  logic [15:0] o_dac;
  logic        o_ramp_valid;
  logic        o_ramp_wrap;
  logic [15:0] o_drop_cnt;
  logic        o_busy;
  logic [2:0]  o_cstate;

  int n_tests = 0;
  int n_fail  = 0;

  int       m_step;
  bit [31:0] m_ramp;
  bit       m_wrap;
  int       m_drop;

  always #5 clk = ~clk;

  my_step_ramp_gen_v1 dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_loop_mode  (i_loop_mode),
    .i_err_valid  (i_err_valid),
    .i_err        (i_err),
    .i_gain_sel   (i_gain_sel),
    .i_step_lim   (i_step_lim),
    .i_const_step (i_const_step),
    .o_step       (o_step),
    .o_ramp       (o_ramp),
    .o_dac        (o_dac),
    .o_ramp_valid (o_ramp_valid),
    .o_ramp_wrap  (o_ramp_wrap),
    .o_drop_cnt   (o_drop_cnt),
    .o_busy       (o_busy),
    .o_cstate     (o_cstate)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // Arithmetic right shift expressed as floor division by 2^sh.
  function automatic longint floor_shift(input longint v, input int sh);
    longint d;
    longint r;
    d = longint'(1) << sh;
    r = v % d;
    if (r < 0) r += d;
    return (v - r) / d;
  endfunction

  // Advance the model by one accepted strobe, using the currently driven configuration.
  task automatic model_apply(input int err);
    longint es;
    longint s;
    longint lim;
    longint sum;
    es  = floor_shift(longint'(err), int'(i_gain_sel));
    lim = longint'(i_step_lim);
    if (i_loop_mode) begin
      s = longint'(m_step) + es;
      if (s > lim)  s = lim;
      if (s < -lim) s = -lim;
      m_step = int'(s);
    end else begin
      m_step = int'(i_const_step);
    end
    sum    = longint'(int'(m_ramp)) + longint'(m_step);
    m_wrap = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
    m_ramp = m_ramp + 32'(m_step);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_rst       = 1'b1;
    i_enable    = 1'b0;
    i_err_valid = 1'b0;
    repeat (2) @(negedge clk);
    i_rst  = 1'b0;
    m_step = 0;
    m_ramp = '0;
    m_wrap = 1'b0;
    m_drop = 0;
  endtask

  task automatic start_loop();
    i_enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_cfg(input bit mode, input int gain, input logic [31:0] lim,
                         input logic [31:0] cst);
    i_loop_mode  = mode;
    i_gain_sel   = 5'(gain);
    i_step_lim   = lim;
    i_const_step = cst;
  endtask

  // Drives one strobe, waits (bounded) for the valid pulse and returns what was seen.
  task automatic do_strobe(input int err, output int lat, output logic [31:0] step,
                           output logic [31:0] ramp, output logic wrap,
                           output logic [15:0] dac, output logic busy,
                           output bit one_cycle);
    @(negedge clk);
    i_err_valid = 1'b1;
    i_err       = err;
    @(negedge clk);
    i_err_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (o_ramp_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    step = o_step;
    ramp = o_ramp;
    wrap = o_ramp_wrap;
    dac  = o_dac;
    busy = o_busy;
    @(negedge clk);
    one_cycle = (o_ramp_valid === 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (o_step !== 32'd0) begin n_fail++; $display("FAIL reset_step: got %0h exp 0", o_step); end
    n_tests++; if (o_ramp !== 32'd0) begin n_fail++; $display("FAIL reset_ramp: got %0h exp 0", o_ramp); end
    n_tests++; if (o_dac !== 16'd0) begin n_fail++; $display("FAIL reset_dac: got %0h exp 0", o_dac); end
    n_tests++; if (o_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d exp 0", o_drop_cnt); end
    n_tests++; if (o_ramp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", o_ramp_valid); end
    n_tests++; if (o_ramp_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b exp 0", o_ramp_wrap); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", o_busy); end
    n_tests++; if (o_cstate !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", o_cstate); end
    start_loop();
    n_tests++; if (o_cstate !== 3'd1) begin n_fail++; $display("FAIL enable_state: got %0d exp 1", o_cstate); end
  endtask

  task automatic test_closed_basic();
    int lat; logic [31:0] st, rp; logic wr, bz; logic [15:0] dc; bit one;
    set_cfg(1'b1, 0, 32'd1000, 32'd0);
    for (int i = 0; i < 3; i++) begin
      model_apply(100);
      do_strobe(100, lat, st, rp, wr, dc, bz, one);
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d exp 4", i, lat); end
      n_tests++; if (st !== 32'(m_step)) begin n_fail++; $display("FAIL basic_step[%0d]: got %0d exp %0d", i, $signed(st), m_step); end
      n_tests++; if (rp !== m_ramp) begin n_fail++; $display("FAIL basic_ramp[%0d]: got %0d exp %0d", i, rp, m_ramp); end
      n_tests++; if (bz !== 1'b1) begin n_fail++; $display("FAIL basic_busy_out[%0d]: got %b exp 1", i, bz); end
      n_tests++; if (!one) begin n_fail++; $display("FAIL basic_pulse_width[%0d]: got >1 cycle exp 1 cycle", i); end
    end
  endtask

  task automatic test_clamp();
    int lat; logic [31:0] st, rp; logic wr, bz; logic [15:0] dc; bit one;
    int errs [2] = '{2000, -5000};
    foreach (errs[i]) begin
      model_apply(errs[i]);
      do_strobe(errs[i], lat, st, rp, wr, dc, bz, one);
      n_tests++; if (st !== 32'(m_step)) begin n_fail++; $display("FAIL clamp_step[%0d]: got %0d exp %0d", i, $signed(st), m_step); end
      n_tests++; if (rp !== m_ramp) begin n_fail++; $display("FAIL clamp_ramp[%0d]: got %0h exp %0h", i, rp, m_ramp); end
    end
  endtask

  task automatic test_gain();
    int lat; logic [31:0] st, rp; logic wr, bz; logic [15:0] dc; bit one;
    apply_reset();
    start_loop();
    set_cfg(1'b1, 4, 32'd1000, 32'd0);
    model_apply(-33);
    do_strobe(-33, lat, st, rp, wr, dc, bz, one);
    n_tests++; if (st !== 32'(m_step)) begin n_fail++; $display("FAIL gain_shift_step: got %0d exp %0d", $signed(st), m_step); end
    n_tests++; if (rp !== m_ramp) begin n_fail++; $display("FAIL gain_shift_ramp: got %0h exp %0h", rp, m_ramp); end
  endtask

  task automatic test_open_loop();
    int lat; logic [31:0] st, rp; logic wr, bz; logic [15:0] dc; bit one;
    set_cfg(1'b0, 0, 32'd1000, 32'd50);
    for (int i = 0; i < 3; i++) begin
      int e;
      e = int'($urandom);
      model_apply(e);
      do_strobe(e, lat, st, rp, wr, dc, bz, one);
      n_tests++; if (st !== 32'(m_step)) begin n_fail++; $display("FAIL open_step[%0d]: got %0d exp %0d", i, $signed(st), m_step); end
      n_tests++; if (rp !== m_ramp) begin n_fail++; $display("FAIL open_ramp[%0d]: got %0h exp %0h", i, rp, m_ramp); end
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] st, rp; logic wr, bz; logic [15:0] dc; bit one;
    apply_reset();
    start_loop();
    set_cfg(1'b0, 0, 32'd0, 32'h3FFF_FF80);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) i_const_step = 32'h0000_0200;
      model_apply(0);
      do_strobe(0, lat, st, rp, wr, dc, bz, one);
      n_tests++; if (rp !== m_ramp) begin n_fail++; $display("FAIL wrap_ramp[%0d]: got %0h exp %0h", i, rp, m_ramp); end
      n_tests++; if (wr !== m_wrap) begin n_fail++; $display("FAIL wrap_flag[%0d]: got %b exp %b", i, wr, m_wrap); end
      n_tests++; if (dc !== m_ramp[31:16]) begin n_fail++; $display("FAIL wrap_dac[%0d]: got %0h exp %0h", i, dc, m_ramp[31:16]); end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    apply_reset();
    start_loop();
    set_cfg(1'b1, 0, 32'd1000, 32'd0);
    model_apply(100);
    @(negedge clk); i_err_valid = 1'b1; i_err = 32'd100;
    @(negedge clk); i_err_valid = 1'b0;
    @(negedge clk); i_err_valid = 1'b1; i_err = 32'd500;
    m_drop++;
    @(negedge clk); i_err_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_ramp_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL b2b_valid: got no pulse exp pulse"); end
    n_tests++; if (o_step !== 32'(m_step)) begin n_fail++; $display("FAIL b2b_step: got %0d exp %0d", $signed(o_step), m_step); end
    n_tests++; if (o_ramp !== m_ramp) begin n_fail++; $display("FAIL b2b_ramp: got %0d exp %0d", o_ramp, m_ramp); end
    n_tests++; if (o_drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL b2b_drop: got %0d exp %0d", o_drop_cnt, m_drop); end
    // Strobe presented during the OUT cycle must also be dropped.
    i_err_valid = 1'b1; i_err = 32'd700;
    m_drop++;
    @(negedge clk); i_err_valid = 1'b0;
    n_tests++; if (o_drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL out_drop: got %0d exp %0d", o_drop_cnt, m_drop); end
    n_tests++; if (o_cstate !== 3'd1) begin n_fail++; $display("FAIL out_drop_state: got %0d exp 1", o_cstate); end
    repeat (6) @(negedge clk);
    n_tests++; if (o_step !== 32'(m_step)) begin n_fail++; $display("FAIL out_drop_step: got %0d exp %0d", $signed(o_step), m_step); end
  endtask

  task automatic test_lim_zero();
    int lat; logic [31:0] st, rp; logic wr, bz; logic [15:0] dc; bit one;
    set_cfg(1'b1, 0, 32'd0, 32'd0);
    model_apply(12345);
    do_strobe(12345, lat, st, rp, wr, dc, bz, one);
    n_tests++; if (st !== 32'(m_step)) begin n_fail++; $display("FAIL lim0_step: got %0d exp %0d", $signed(st), m_step); end
    n_tests++; if (rp !== m_ramp) begin n_fail++; $display("FAIL lim0_ramp: got %0d exp %0d", rp, m_ramp); end
  endtask

  task automatic test_enable_drop();
    bit reached;
    bit pulse;
    set_cfg(1'b1, 0, 32'd1000, 32'd0);
    @(negedge clk); i_err_valid = 1'b1; i_err = 32'd400;
    @(negedge clk); i_err_valid = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_cstate === 3'd3) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!reached) begin n_fail++; $display("FAIL endrop_reach_integ: got state %0d exp 3", o_cstate); end
    i_enable = 1'b0;
    @(negedge clk);
    n_tests++; if (o_cstate !== 3'd0) begin n_fail++; $display("FAIL endrop_state: got %0d exp 0", o_cstate); end
    pulse = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (o_ramp_valid !== 1'b0) pulse = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (pulse) begin n_fail++; $display("FAIL endrop_no_valid: got pulse exp none"); end
    n_tests++; if (o_step !== 32'(m_step)) begin n_fail++; $display("FAIL endrop_step_hold: got %0d exp %0d", $signed(o_step), m_step); end
    n_tests++; if (o_ramp !== m_ramp) begin n_fail++; $display("FAIL endrop_ramp_hold: got %0d exp %0d", o_ramp, m_ramp); end
    start_loop();
    n_tests++; if (o_cstate !== 3'd1) begin n_fail++; $display("FAIL endrop_restart: got %0d exp 1", o_cstate); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] st, rp; logic wr, bz; logic [15:0] dc; bit one; bit reached;
    set_cfg(1'b1, 0, 32'd1000, 32'd0);
    model_apply(250);
    do_strobe(250, lat, st, rp, wr, dc, bz, one);
    n_tests++; if (rp !== m_ramp) begin n_fail++; $display("FAIL rstmid_pre_ramp: got %0d exp %0d", rp, m_ramp); end
    @(negedge clk); i_err_valid = 1'b1; i_err = 32'd300;
    @(negedge clk); i_err_valid = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_cstate === 3'd4) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!reached) begin n_fail++; $display("FAIL rstmid_reach_ramp: got state %0d exp 4", o_cstate); end
    i_rst = 1'b1;
    @(negedge clk);
    n_tests++; if (o_step !== 32'd0) begin n_fail++; $display("FAIL rstmid_step: got %0h exp 0", o_step); end
    n_tests++; if (o_ramp !== 32'd0) begin n_fail++; $display("FAIL rstmid_ramp: got %0h exp 0", o_ramp); end
    n_tests++; if (o_dac !== 16'd0) begin n_fail++; $display("FAIL rstmid_dac: got %0h exp 0", o_dac); end
    n_tests++; if (o_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop: got %0d exp 0", o_drop_cnt); end
    n_tests++; if (o_ramp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b exp 0", o_ramp_valid); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b exp 0", o_busy); end
    n_tests++; if (o_cstate !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d exp 0", o_cstate); end
    i_rst = 1'b0;
    m_step = 0; m_ramp = '0; m_wrap = 1'b0; m_drop = 0;
    i_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat; logic [31:0] st, rp; logic wr, bz; logic [15:0] dc; bit one;
    apply_reset();
    start_loop();
    for (int i = 0; i < 40; i++) begin
      int e;
      logic [31:0] lim;
      lim = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 65536)) : ($urandom & 32'h7FFF_FFFF);
      set_cfg(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), lim, $urandom);
      e = int'($urandom);
      model_apply(e);
      do_strobe(e, lat, st, rp, wr, dc, bz, one);
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d exp 4", i, lat); end
      n_tests++; if (st !== 32'(m_step)) begin n_fail++; $display("FAIL rand_step[%0d]: got %0h exp %0h", i, st, m_step); end
      n_tests++; if (rp !== m_ramp) begin n_fail++; $display("FAIL rand_ramp[%0d]: got %0h exp %0h", i, rp, m_ramp); end
      n_tests++; if (wr !== m_wrap) begin n_fail++; $display("FAIL rand_wrap[%0d]: got %b exp %b", i, wr, m_wrap); end
    end
  endtask

  initial begin
    m_step = 0; m_ramp = '0; m_wrap = 1'b0; m_drop = 0;
    test_reset();
    test_closed_basic();
    test_clamp();
    test_gain();
    test_open_loop();
    test_wrap();
    test_back_to_back();
    test_lim_zero();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
